// File: rtl/equalizer_input_stage.sv
// ----------------------------------------------------------------------------
// equalizer_input_stage
//
// Purpose:
//   Upstream sample-delivery stage for the 8-band equalizer. Source samples
//   arrive over a valid/ready handshake and are buffered in a small FIFO.
//   Once enough samples are buffered (priming), one sample is presented on
//   filter_in every SAMPLE_PERIOD clocks. clk_enable drives the equalizer's
//   global enable. If a sample slot finds the FIFO empty, zero is sent and
//   the sticky underrun flag is raised.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   enable         in   run request (level)
//   in_valid       in   source sample valid
//   in_ready       out  FIFO can accept a sample (not full)
//   in_data        in   signed source sample
//   filter_in      out  signed sample to the equalizer (registered)
//   clk_enable     out  equalizer global enable (registered)
//   sample_strobe  out  one-cycle pulse with each new filter_in value
//   fifo_level     out  current FIFO occupancy
//   underrun       out  sticky: a sample slot found the FIFO empty
//   underrun_clear in   synchronous clear of underrun
// ----------------------------------------------------------------------------
module equalizer_input_stage #(
    parameter int FILTER_IN_BITS = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int SAMPLE_PERIOD  = 64,
    parameter int PRIME_LEVEL    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [FILTER_IN_BITS-1:0] in_data,
    output logic signed [FILTER_IN_BITS-1:0] filter_in,
    output logic                             clk_enable,
    output logic                             sample_strobe,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             underrun,
    input  logic                             underrun_clear
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = ADDR_W + 1;
    localparam int COUNT_W = $clog2(SAMPLE_PERIOD);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL  = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] LEVEL_PRIME = LEVEL_W'(PRIME_LEVEL);
    localparam logic [COUNT_W-1:0] COUNT_LAST  = COUNT_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } StageState;

    // FIFO storage and bookkeeping
    logic signed [FILTER_IN_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]                r_wrPtr;
    logic [ADDR_W-1:0]                r_rdPtr;
    logic [LEVEL_W-1:0]               r_level;

    // Control state
    StageState                        r_state;
    StageState                        w_nextState;
    logic [COUNT_W-1:0]               r_count;

    // Output registers
    logic signed [FILTER_IN_BITS-1:0] r_filterIn;
    logic                             r_clkEnable;
    logic                             r_sampleStrobe;
    logic                             r_underrun;

    // Internal strobes
    logic                             w_full;
    logic                             w_empty;
    logic                             w_push;
    logic                             w_pop;
    logic                             w_slot;
    logic                             w_primed;
    logic signed [FILTER_IN_BITS-1:0] w_head;

    // Occupancy-derived flags. in_ready looks only at the current level, so
    // a full FIFO refuses data even in a cycle where a pop frees an entry.
    assign w_full   = (r_level == LEVEL_FULL);
    assign w_empty  = (r_level == '0);
    assign w_primed = (r_level >= LEVEL_PRIME);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rdPtr];

    // A slot is the counter==0 cycle in RUN. It is suppressed when enable has
    // just dropped, so filter_in keeps its last value as we fall back to IDLE.
    assign w_slot = (r_state == RUN) && (r_count == '0) && enable;
    assign w_pop  = w_slot && !w_empty;

    // Sample storage. Contents need no reset: emptiness is tracked by the
    // pointers and level, which are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    // FIFO pointers and level. Pointers wrap naturally because the depth is a
    // power of two. A simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Dropping enable returns to IDLE from any state;
    // priming completes as soon as the buffered level reaches PRIME_LEVEL.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_nextState = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    w_nextState = IDLE;
                end else if (w_primed) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Period counter: free-runs only while staying in RUN, so every entry
    // into RUN (and every return to IDLE) starts from zero and the first
    // RUN cycle is a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if ((r_state == RUN) && (w_nextState == RUN)) begin
            if (r_count == COUNT_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + COUNT_W'(1);
            end
        end else begin
            r_count <= '0;
        end
    end

    // Sample delivery. An empty FIFO at a slot sends zero instead of the
    // head; the strobe fires for every slot either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filterIn     <= '0;
            r_sampleStrobe <= 1'b0;
        end else begin
            r_sampleStrobe <= w_slot;
            if (w_slot) begin
                r_filterIn <= w_empty ? '0 : w_head;
            end
        end
    end

    // Equalizer enable: rises together with the first sample load and falls
    // on the edge that takes us back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkEnable <= 1'b0;
        end else if (w_nextState == IDLE) begin
            r_clkEnable <= 1'b0;
        end else if (w_slot) begin
            r_clkEnable <= 1'b1;
        end
    end

    // Sticky underrun flag; a new underrun takes priority over a clear
    // request in the same cycle so no event is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_slot && w_empty) begin
            r_underrun <= 1'b1;
        end else if (underrun_clear) begin
            r_underrun <= 1'b0;
        end
    end

    assign in_ready      = !w_full;
    assign filter_in     = r_filterIn;
    assign clk_enable    = r_clkEnable;
    assign sample_strobe = r_sampleStrobe;
    assign fifo_level    = r_level;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_equalizer_input_stage.sv
// ----------------------------------------------------------------------------
// tb_equalizer_input_stage
//
// Purpose:
//   Directed, self-checking bench for equalizer_input_stage with default
//   parameters (16-bit samples, 16-entry FIFO, 64-clock period, prime 4).
//   Expected samples go into a scoreboard queue as they are driven and are
//   popped when the DUT strobes a new filter_in value.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_equalizer_input_stage;

    localparam int PERIOD = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] filter_in;
    logic        clk_enable;
    logic        sample_strobe;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic        underrun_clear;

    int          checkCount = 0;
    int          errorCount = 0;
    int          cycle = 0;
    int          lastStrobe = 0;
    logic [15:0] sbQ [$];

    equalizer_input_stage dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .filter_in      (filter_in),
        .clk_enable     (clk_enable),
        .sample_strobe  (sample_strobe),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .underrun_clear (underrun_clear)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Hard stop in case the design never produces an awaited event.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge where a strobe is expected: checks the strobe,
    // the equalizer enable and the delivered sample against the scoreboard.
    task automatic checkStrobeNow(input string tag);
        logic [15:0] expData;
        checkOutput({tag, "_strobe"}, 32'(sample_strobe), 32'd1);
        checkOutput({tag, "_clkEnable"}, 32'(clk_enable), 32'd1);
        if (sbQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $error("[TB] FAIL %s_scoreboard: observed strobe expected empty scoreboard", tag);
        end else begin
            expData = sbQ.pop_front();
            checkOutput({tag, "_data"}, 32'(filter_in), 32'(expData));
        end
        lastStrobe = cycle;
    endtask

    // Waits (bounded) for the next strobe and checks it lands exactly
    // 'delay' clocks after refCycle.
    task automatic expectStrobe(input string tag, input int refCycle, input int delay);
        do begin
            tick();
        end while (sample_strobe !== 1'b1 && (cycle - refCycle) < delay + 8);
        checkOutput({tag, "_delay"}, 32'(cycle - refCycle), 32'(delay));
        checkStrobeNow(tag);
    endtask

    initial begin
        int refCycle;
        int accepted;
        int strobes;
        int enHigh;

        rst            = 1'b1;
        enable         = 1'b0;
        underrun_clear = 1'b0;
        applyStimulus(1'b0, 16'h0000);

        // Power-on reset values
        repeat (3) tick();
        checkOutput("rst_filterIn", 32'(filter_in), 32'd0);
        checkOutput("rst_clkEnable", 32'(clk_enable), 32'd0);
        checkOutput("rst_strobe", 32'(sample_strobe), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_inReady", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Priming: enable and push 1..4; first strobe two clocks after the
        // fourth push is counted, then 64-clock spacing.
        $display("[TB] priming");
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 16'(k));
            sbQ.push_back(16'(k));
            tick();
        end
        applyStimulus(1'b0, 16'h0000);
        checkOutput("prime_level", 32'(fifo_level), 32'd4);
        checkOutput("prime_clkEnableLow", 32'(clk_enable), 32'd0);
        refCycle = cycle;
        expectStrobe("prime_s1", refCycle, 2);
        expectStrobe("prime_s2", lastStrobe, PERIOD);
        expectStrobe("prime_s3", lastStrobe, PERIOD);
        expectStrobe("prime_s4", lastStrobe, PERIOD);

        // Underrun: nothing pushed, fifth slot delivers zero and latches.
        $display("[TB] underrun");
        checkOutput("ur_before", 32'(underrun), 32'd0);
        sbQ.push_back(16'h0000);
        expectStrobe("ur_s5", lastStrobe, PERIOD);
        checkOutput("ur_set", 32'(underrun), 32'd1);
        repeat (5) tick();
        checkOutput("ur_sticky", 32'(underrun), 32'd1);
        underrun_clear = 1'b1;
        tick();
        underrun_clear = 1'b0;
        checkOutput("ur_cleared", 32'(underrun), 32'd0);

        // Refill a little so a mid-run reset has non-zero state to discard.
        applyStimulus(1'b1, 16'h00A5);
        sbQ.push_back(16'h00A5);
        tick();
        applyStimulus(1'b1, 16'h0BEE);
        sbQ.push_back(16'h0BEE);
        tick();
        applyStimulus(1'b0, 16'h0000);
        expectStrobe("refill", lastStrobe, PERIOD);
        checkOutput("refill_level", 32'(fifo_level), 32'd1);

        // Reset mid-run, asserted between clock edges.
        $display("[TB] reset mid-run");
        repeat (3) tick();
        #3;
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("arst_clkEnable", 32'(clk_enable), 32'd0);
        checkOutput("arst_strobe", 32'(sample_strobe), 32'd0);
        checkOutput("arst_filterIn", 32'(filter_in), 32'd0);
        checkOutput("arst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
        strobes = 0;
        enHigh  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            strobes += int'(sample_strobe);
            enHigh  += int'(clk_enable);
        end
        // Enabled but never primed: still no strobes.
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            strobes += int'(sample_strobe);
            enHigh  += int'(clk_enable);
        end
        enable = 1'b0;
        tick();
        checkOutput("arst_noStrobe", 32'(strobes), 32'd0);
        checkOutput("arst_noClkEnable", 32'(enHigh), 32'd0);
        checkOutput("arst_levelAfter", 32'(fifo_level), 32'd0);

        // Full: 20 offered with in_valid held, exactly 16 accepted.
        $display("[TB] full");
        accepted = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 16'(k));
            if (in_ready === 1'b1) begin
                accepted++;
            end
            if (k <= 16) begin
                sbQ.push_back(16'(k));
            end
            tick();
        end
        applyStimulus(1'b0, 16'h0000);
        checkOutput("full_accepted", 32'(accepted), 32'd16);
        checkOutput("full_level", 32'(fifo_level), 32'd16);
        checkOutput("full_inReady", 32'(in_ready), 32'd0);

        // Enable from IDLE: IDLE->PRIME, PRIME->RUN, slot -> strobe.
        refCycle = cycle;
        enable   = 1'b1;
        expectStrobe("full_s1", refCycle, 3);
        for (int i = 2; i <= 13; i++) begin
            expectStrobe($sformatf("full_s%0d", i), lastStrobe, PERIOD);
        end

        // Simultaneous push and pop at a slot with three entries.
        $display("[TB] push at slot");
        repeat (PERIOD - 1) tick();
        checkOutput("pp_levelBefore", 32'(fifo_level), 32'd3);
        applyStimulus(1'b1, 16'h1234);
        sbQ.push_back(16'h1234);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkStrobeNow("pp_slot");
        checkOutput("pp_levelAfter", 32'(fifo_level), 32'd3);
        expectStrobe("pp_s15", lastStrobe, PERIOD);
        expectStrobe("pp_s16", lastStrobe, PERIOD);
        expectStrobe("pp_new", lastStrobe, PERIOD);
        checkOutput("pp_drained", 32'(fifo_level), 32'd0);

        // Push into an empty FIFO at the slot, with a clear request in the
        // same cycle: zero goes out, underrun still sets, sample comes next.
        repeat (PERIOD - 1) tick();
        checkOutput("pe_levelBefore", 32'(fifo_level), 32'd0);
        checkOutput("pe_underrunBefore", 32'(underrun), 32'd0);
        applyStimulus(1'b1, 16'h5A5A);
        underrun_clear = 1'b1;
        sbQ.push_back(16'h0000);
        sbQ.push_back(16'h5A5A);
        tick();
        applyStimulus(1'b0, 16'h0000);
        underrun_clear = 1'b0;
        checkStrobeNow("pe_slot");
        checkOutput("pe_setWins", 32'(underrun), 32'd1);
        checkOutput("pe_levelAfter", 32'(fifo_level), 32'd1);
        expectStrobe("pe_next", lastStrobe, PERIOD);

        // Disable mid-run at counter 30 (the strobe cycle sees counter 1).
        $display("[TB] disable mid-run");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 16'(16'h0101 + j));
            sbQ.push_back(16'(16'h0101 + j));
            tick();
        end
        applyStimulus(1'b0, 16'h0000);
        repeat (25) tick();
        enable = 1'b0;
        tick();
        checkOutput("dis_clkEnable", 32'(clk_enable), 32'd0);
        checkOutput("dis_filterIn", 32'(filter_in), 32'h5A5A);
        checkOutput("dis_level", 32'(fifo_level), 32'd4);
        repeat (10) tick();
        checkOutput("dis_heldFilterIn", 32'(filter_in), 32'h5A5A);
        checkOutput("dis_heldLevel", 32'(fifo_level), 32'd4);
        checkOutput("dis_heldStrobe", 32'(sample_strobe), 32'd0);

        // Re-enable with level >= 4: PRIME passes in one cycle, strobe two
        // cycles after the prime condition holds.
        refCycle = cycle;
        enable   = 1'b1;
        expectStrobe("re_s1", refCycle, 3);
        expectStrobe("re_s2", lastStrobe, PERIOD);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
